// File: rtl/tracker_link_pkg.sv
// rtl/tracker_link_pkg.sv - shared constants and encodings for the tracker serial link
package tracker_link_pkg;

  localparam logic [7:0] FRAME_HEADER  = 8'hA5;
  localparam int         PAYLOAD_BYTES = 13;
  localparam int         SENSOR_ITER_W = 102;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_FRAMING  = 2'b01,
    ERR_CHECKSUM = 2'b10,
    ERR_TIMEOUT  = 2'b11
  } err_code_t;

  typedef enum logic [1:0] {
    F_HUNT,
    F_PAYLOAD,
    F_CHECK,
    F_COMMIT
  } frame_state_t;

  typedef enum logic [2:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_STOP,
    B_WAIT_HIGH
  } byte_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 byte receiver with 2-FF input synchroniser
module uart_rx_byte
  import tracker_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_ferr
);

  localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  byte_state_t      r_state, w_state_nxt;
  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_bit_idx, w_bit_idx_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic [2:0]       r_valid_pipe, r_ferr_pipe;
  logic             w_valid_nxt, w_ferr_nxt;
  logic             w_rx;

  assign w_rx = r_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync       <= 2'b11;
      r_state      <= B_IDLE;
      r_cnt        <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_valid_pipe <= '0;
      r_ferr_pipe  <= '0;
    end else begin
      r_sync       <= {r_sync[0], rx};
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_bit_idx    <= w_bit_idx_nxt;
      r_shift      <= w_shift_nxt;
      r_valid_pipe <= {r_valid_pipe[1:0], w_valid_nxt};
      r_ferr_pipe  <= {r_ferr_pipe[1:0], w_ferr_nxt};
    end
  end

  // IDLE is only ever entered with the line high, so a low level there is a falling edge
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_valid_nxt   = 1'b0;
    w_ferr_nxt    = 1'b0;
    case (r_state)
      B_IDLE: begin
        if (!w_rx) begin
          w_state_nxt = B_START;
          w_cnt_nxt   = '0;
        end
      end
      B_START: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt_nxt     = '0;
          w_bit_idx_nxt = '0;
          w_state_nxt   = w_rx ? B_IDLE : B_DATA;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      B_DATA: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_rx, r_shift[7:1]};
          if (r_bit_idx == 3'd7) w_state_nxt = B_STOP;
          else                   w_bit_idx_nxt = r_bit_idx + 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      B_STOP: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_nxt = '0;
          if (w_rx) begin
            w_valid_nxt = 1'b1;
            w_state_nxt = B_IDLE;
          end else begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = B_WAIT_HIGH;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      B_WAIT_HIGH: begin
        if (w_rx) w_state_nxt = B_IDLE;
      end
      default: w_state_nxt = B_IDLE;
    endcase
  end

  assign byte_data  = r_shift;
  assign byte_valid = r_valid_pipe[2];
  assign byte_ferr  = r_ferr_pipe[2];

endmodule

// File: rtl/sensor_frame_receiver.sv
// rtl/sensor_frame_receiver.sv - tracker link receiver: byte UART plus header/payload/checksum parser
module sensor_frame_receiver #(
  parameter int         CLKS_PER_BIT  = 12,
  parameter logic [7:0] FRAME_HEADER  = tracker_link_pkg::FRAME_HEADER,
  parameter int         PAYLOAD_BYTES = tracker_link_pkg::PAYLOAD_BYTES,
  parameter int         TIMEOUT_BITS  = 20
) (
  input  logic                                      clk_12MHz,
  input  logic                                      reset_n,
  input  logic                                      rx,
  output logic [tracker_link_pkg::SENSOR_ITER_W-1:0] sensor_iterations,
  output logic                                      frame_valid,
  output logic                                      frame_error,
  output logic [1:0]                                error_code
);

  localparam int               ITER_W     = tracker_link_pkg::SENSOR_ITER_W;
  localparam int               SHADOW_W   = PAYLOAD_BYTES * 8;
  localparam int               PAD_W      = SHADOW_W - ITER_W;
  localparam int               IDX_W      = $clog2(PAYLOAD_BYTES);
  localparam int               TMO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int               TMO_W      = $clog2(TMO_CYCLES + 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(PAYLOAD_BYTES - 1);
  localparam logic [TMO_W-1:0] TMO_MAX    = TMO_W'(TMO_CYCLES);

  logic [7:0] w_byte_data;
  logic       w_byte_valid, w_byte_ferr;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk_12MHz),
    .rst_n     (reset_n),
    .rx        (rx),
    .byte_data (w_byte_data),
    .byte_valid(w_byte_valid),
    .byte_ferr (w_byte_ferr)
  );

  tracker_link_pkg::frame_state_t r_fstate, w_fstate_nxt;
  tracker_link_pkg::err_code_t    w_err_code;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt;
  logic [7:0]        r_chk, w_chk_nxt;
  logic [SHADOW_W-1:0] r_shadow, w_shadow_nxt;
  logic [TMO_W-1:0]  r_tmo, w_tmo_nxt;
  logic [ITER_W-1:0] r_sensor, w_sensor_nxt;
  logic              r_frame_valid, w_fv_nxt;
  logic              r_frame_error;
  logic [1:0]        r_error_code, w_ec_nxt;
  logic              w_err;

  always_ff @(posedge clk_12MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_fstate      <= tracker_link_pkg::F_HUNT;
      r_idx         <= '0;
      r_chk         <= '0;
      r_shadow      <= '0;
      r_tmo         <= '0;
      r_sensor      <= '0;
      r_frame_valid <= 1'b0;
      r_frame_error <= 1'b0;
      r_error_code  <= '0;
    end else begin
      r_fstate      <= w_fstate_nxt;
      r_idx         <= w_idx_nxt;
      r_chk         <= w_chk_nxt;
      r_shadow      <= w_shadow_nxt;
      r_tmo         <= w_tmo_nxt;
      r_sensor      <= w_sensor_nxt;
      r_frame_valid <= w_fv_nxt;
      r_frame_error <= w_err;
      r_error_code  <= w_ec_nxt;
    end
  end

  always_comb begin
    w_fstate_nxt = r_fstate;
    w_idx_nxt    = r_idx;
    w_chk_nxt    = r_chk;
    w_shadow_nxt = r_shadow;
    w_tmo_nxt    = r_tmo;
    w_sensor_nxt = r_sensor;
    w_fv_nxt     = 1'b0;
    w_ec_nxt     = r_error_code;
    w_err        = 1'b0;
    w_err_code   = tracker_link_pkg::ERR_NONE;
    case (r_fstate)
      tracker_link_pkg::F_HUNT: begin
        w_tmo_nxt = '0;
        if (w_byte_valid && (w_byte_data == FRAME_HEADER)) begin
          w_fstate_nxt = tracker_link_pkg::F_PAYLOAD;
          w_idx_nxt    = '0;
          w_chk_nxt    = '0;
        end
      end
      tracker_link_pkg::F_PAYLOAD, tracker_link_pkg::F_CHECK: begin
        if (w_byte_ferr) begin
          w_err      = 1'b1;
          w_err_code = tracker_link_pkg::ERR_FRAMING;
        end else if (w_byte_valid) begin
          w_tmo_nxt = '0;
          if (r_fstate == tracker_link_pkg::F_PAYLOAD) begin
            for (int k = 0; k < PAYLOAD_BYTES; k++) begin
              if (r_idx == IDX_W'(k)) w_shadow_nxt[k*8 +: 8] = w_byte_data;
            end
            w_chk_nxt = r_chk ^ w_byte_data;
            if (r_idx == IDX_LAST) w_fstate_nxt = tracker_link_pkg::F_CHECK;
            else                   w_idx_nxt    = r_idx + 1'b1;
          end else if ((w_byte_data == r_chk) && (r_shadow[SHADOW_W-1 -: PAD_W] == '0)) begin
            w_fstate_nxt = tracker_link_pkg::F_COMMIT;
          end else begin
            w_err      = 1'b1;
            w_err_code = tracker_link_pkg::ERR_CHECKSUM;
          end
        end else if (r_tmo == TMO_MAX) begin
          w_err      = 1'b1;
          w_err_code = tracker_link_pkg::ERR_TIMEOUT;
        end else begin
          w_tmo_nxt = r_tmo + 1'b1;
        end
      end
      tracker_link_pkg::F_COMMIT: begin
        w_sensor_nxt = r_shadow[ITER_W-1:0];
        w_fv_nxt     = 1'b1;
        w_tmo_nxt    = '0;
        w_fstate_nxt = tracker_link_pkg::F_HUNT;
      end
      default: w_fstate_nxt = tracker_link_pkg::F_HUNT;
    endcase
    // Any drop abandons the shadow contents; only COMMIT ever touches the output word
    if (w_err) begin
      w_ec_nxt     = w_err_code;
      w_fstate_nxt = tracker_link_pkg::F_HUNT;
    end
  end

  assign sensor_iterations = r_sensor;
  assign frame_valid       = r_frame_valid;
  assign frame_error       = r_frame_error;
  assign error_code        = r_error_code;

endmodule

// File: tb/tb_sensor_frame_receiver.sv
// tb/tb_sensor_frame_receiver.sv - scoreboard bench for sensor_frame_receiver
`timescale 1ns/1ps
module tb_sensor_frame_receiver;

  localparam int           CPB = 12;
  localparam logic [101:0] P1  = 102'h2A_5555_5555_AAAA_AAAA_0F0F_0F;
  localparam logic [101:0] P2  = 102'h2_FEDC_BA98_7654_3210_0123_4567;
  localparam logic [101:0] P3  = 102'h1_3579_BDF0_2468_ACE1_1357_9BDF;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         rx;
  logic [101:0] sensor_iterations;
  logic         frame_valid;
  logic         frame_error;
  logic [1:0]   error_code;

  int           n_vec  = 0;
  int           n_miss = 0;
  logic [101:0] exp_q[$];
  logic [1:0]   err_q[$];

  always #5 clk = ~clk;

  sensor_frame_receiver #(
    .CLKS_PER_BIT (CPB),
    .FRAME_HEADER (8'hA5),
    .PAYLOAD_BYTES(13),
    .TIMEOUT_BITS (20)
  ) dut (
    .clk_12MHz        (clk),
    .reset_n          (reset_n),
    .rx               (rx),
    .sensor_iterations(sensor_iterations),
    .frame_valid      (frame_valid),
    .frame_error      (frame_error),
    .error_code       (error_code)
  );

  function automatic logic [119:0] frame_bytes(input logic [101:0] p, input logic [7:0] flip);
    logic [103:0] body;
    logic [7:0]   c;
    body = {2'b00, p};
    c    = 8'h00;
    for (int k = 0; k < 13; k++) c ^= body[k*8 +: 8];
    return {c ^ flip, body, 8'hA5};
  endfunction

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop_bit);
  endtask

  task automatic send_range(input logic [119:0] f, input int first, input int last);
    for (int k = first; k <= last; k++) send_byte(f[k*8 +: 8], 1'b1);
  endtask

  task automatic monitor();
    logic [101:0] e;
    logic [1:0]   ec;
    forever begin
      @(negedge clk);
      if (frame_valid && frame_error) begin
        n_vec++;
        n_miss++;
        $display("FAIL pulse_overlap: frame_valid=%b frame_error=%b, required not both", frame_valid, frame_error);
      end
      if (frame_valid) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_miss++;
          $display("FAIL unexpected_frame: got frame_valid with %h, required none", sensor_iterations);
        end else begin
          e = exp_q.pop_front();
          if (sensor_iterations !== e) begin
            n_miss++;
            $display("FAIL frame_payload: got %h, required %h", sensor_iterations, e);
          end
        end
      end
      if (frame_error) begin
        n_vec++;
        if (err_q.size() == 0) begin
          n_miss++;
          $display("FAIL unexpected_error: got frame_error code %b, required none", error_code);
        end else begin
          ec = err_q.pop_front();
          if (error_code !== ec) begin
            n_miss++;
            $display("FAIL error_code: got %b, required %b", error_code, ec);
          end
        end
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || err_q.size() != 0) && i < 300) begin
      @(negedge clk);
      i++;
    end
    n_vec++;
    if (exp_q.size() != 0 || err_q.size() != 0) begin
      n_miss++;
      $display("FAIL %s_drain: %0d frames and %0d errors pending, required 0", name, exp_q.size(), err_q.size());
    end
    repeat (40) @(negedge clk);
  endtask

  task automatic check_zero_outputs(input string name);
    n_vec += 4;
    if (sensor_iterations !== '0) begin n_miss++; $display("FAIL %s_sensor: got %h, required 0", name, sensor_iterations); end
    if (frame_valid !== 1'b0)    begin n_miss++; $display("FAIL %s_valid: got %b, required 0", name, frame_valid); end
    if (frame_error !== 1'b0)    begin n_miss++; $display("FAIL %s_error: got %b, required 0", name, frame_error); end
    if (error_code !== 2'b00)    begin n_miss++; $display("FAIL %s_code: got %b, required 00", name, error_code); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    rx      = 1'b1;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    @(posedge clk);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_clean_frame();
    exp_q.push_back(P1);
    send_range(frame_bytes(P1, 8'h00), 0, 14);
    wait_drain("clean");
  endtask

  task automatic test_bad_checksum();
    err_q.push_back(2'b10);
    send_range(frame_bytes(P2, 8'h01), 0, 14);
    wait_drain("checksum");
    n_vec++;
    if (sensor_iterations !== P1) begin
      n_miss++;
      $display("FAIL checksum_hold: got %h, required %h", sensor_iterations, P1);
    end
  endtask

  task automatic test_glitch();
    rx = 1'b0;
    repeat (50) @(posedge clk);
    rx = 1'b1;
    repeat (40 * CPB) @(posedge clk);
    exp_q.push_back(P3);
    send_range(frame_bytes(P3, 8'h00), 0, 14);
    wait_drain("glitch");
    n_vec++;
    if (error_code !== 2'b10) begin
      n_miss++;
      $display("FAIL glitch_code_hold: got %b, required 10", error_code);
    end
  endtask

  task automatic test_framing();
    logic [119:0] f;
    f = frame_bytes(P1, 8'h00);
    err_q.push_back(2'b01);
    send_range(f, 0, 5);
    send_byte(f[6*8 +: 8], 1'b0);
    rx = 1'b1;
    repeat (20 * CPB) @(posedge clk);
    wait_drain("framing");
    exp_q.push_back(P2);
    send_range(frame_bytes(P2, 8'h00), 0, 14);
    wait_drain("framing_recover");
  endtask

  task automatic test_timeout();
    logic [119:0] f;
    int lat;
    f = frame_bytes(P1, 8'h00);
    err_q.push_back(2'b11);
    send_range(f, 0, 8);
    rx  = 1'b1;
    lat = 0;
    while (!frame_error && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    n_vec++;
    if (lat < 236 || lat > 246) begin
      n_miss++;
      $display("FAIL timeout_latency: got %0d cycles after B7, required 236..246", lat);
    end
    repeat (250 * CPB - lat) @(posedge clk);
    send_range(f, 9, 14);
    wait_drain("timeout");
  endtask

  task automatic test_back_to_back();
    logic [119:0] f;
    f = frame_bytes(P1, 8'h00);
    send_range(f, 0, 9);
    fork
      send_byte(f[10*8 +: 8], 1'b1);
      begin
        repeat (40) @(posedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_zero_outputs("midreset");
        @(posedge clk);
        reset_n = 1'b1;
      end
    join
    rx = 1'b1;
    repeat (30 * CPB) @(posedge clk);
    exp_q.push_back(P3);
    exp_q.push_back(P2);
    send_range(frame_bytes(P3, 8'h00), 0, 14);
    send_range(frame_bytes(P2, 8'h00), 0, 14);
    wait_drain("back_to_back");
    n_vec++;
    if (error_code !== 2'b00) begin
      n_miss++;
      $display("FAIL back_to_back_code: got %b, required 00", error_code);
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_clean_frame();
    test_bad_checksum();
    test_glitch();
    test_framing();
    test_timeout();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
